// File: rtl/dtcore32_mem_arbiter.sv
// dtcore32_mem_arbiter: shares one memory bus port between fetch and data, one transaction in flight
module dtcore32_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  input  logic        imem_kill_i,
  output logic [31:0] imem_rdata_o,
  output logic        imem_rvalid_o,
  output logic        imem_err_o,
  output logic        imem_busy_o,
  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_wstrb_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_rvalid_o,
  output logic        dmem_err_o,
  output logic        dmem_busy_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  state_t state, state_n;
  logic src, src_n, drop, drop_n;
  logic [3:0] starve_cnt, starve_n;
  logic [7:0] tmo_cnt, tmo_n;
  logic imem_act, win_d, win_i, sel_i, req, done, tmo;
  assign imem_act = imem_req_i & ~imem_kill_i;
  assign win_d = (state == IDLE) & ~rst_i & dmem_req_i & ((starve_cnt < 4'(STARVE_LIMIT)) | ~imem_act);
  assign win_i = (state == IDLE) & ~rst_i & ~win_d & imem_act;
  assign done = (state == RESP) & ~rst_i & bus_rvalid_i;
  assign tmo = (TIMEOUT_CYCLES != 0) & (state != IDLE) & ~rst_i & ~done & (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign sel_i = (state == IDLE) ? win_i : src;
  assign req = win_d | win_i | ((state == ADDR) & ~rst_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      src        <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_n;
      src        <= src_n;
      drop       <= drop_n;
      starve_cnt <= starve_n;
      tmo_cnt    <= tmo_n;
    end
  end
  always_comb begin
    state_n  = (state == IDLE) ? ((win_d | win_i) ? (bus_gnt_i ? RESP : ADDR) : IDLE) :
               (done | tmo) ? IDLE : ((state == ADDR) & bus_gnt_i) ? RESP : state;
    src_n    = (win_d | win_i) ? win_i : src;
    drop_n   = (state != IDLE) & ~(done | tmo) & (drop | (imem_kill_i & src));
    starve_n = win_i ? 4'd0 : (win_d & imem_act) ? starve_cnt + 4'd1 : starve_cnt;
    tmo_n    = (state == IDLE) ? 8'd0 : tmo_cnt + 8'd1;
  end
  always_comb begin
    bus_req_o     = req;
    bus_we_o      = req & ~sel_i & dmem_we_i;
    bus_wstrb_o   = (req & ~sel_i) ? dmem_wstrb_i : 4'd0;
    bus_addr_o    = req ? (sel_i ? imem_addr_i : dmem_addr_i) : 32'd0;
    bus_wdata_o   = (req & ~sel_i) ? dmem_wdata_i : 32'd0;
    imem_rdata_o  = bus_rdata_i;
    dmem_rdata_o  = bus_rdata_i;
    imem_rvalid_o = done & src & ~drop & ~imem_kill_i;
    dmem_rvalid_o = done & ~src;
    imem_err_o    = tmo & src & ~drop & ~imem_kill_i;
    dmem_err_o    = tmo & ~src;
    imem_busy_o   = ~rst_i & imem_act & ~imem_rvalid_o & ~imem_err_o;
    dmem_busy_o   = ~rst_i & dmem_req_i & ~dmem_rvalid_o & ~dmem_err_o;
  end
endmodule

// File: tb/tb_dtcore32_mem_arbiter.sv
// tb_dtcore32_mem_arbiter: directed checks of arbitration, kill, starvation, timeout and reset
module tb_dtcore32_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req = 1'b0, imem_kill = 1'b0, dmem_req = 1'b0, dmem_we = 1'b0;
  logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, bus_rdata = '0;
  logic [3:0] dmem_wstrb = '0;
  logic bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] imem_rdata, dmem_rdata, bus_addr, bus_wdata;
  logic imem_rvalid, imem_err, imem_busy, dmem_rvalid, dmem_err, dmem_busy, bus_req, bus_we;
  logic [3:0] bus_wstrb;
  int errors = 0, checks = 0;
  dtcore32_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_i(imem_req), .imem_addr_i(imem_addr), .imem_kill_i(imem_kill),
    .imem_rdata_o(imem_rdata), .imem_rvalid_o(imem_rvalid), .imem_err_o(imem_err), .imem_busy_o(imem_busy),
    .dmem_req_i(dmem_req), .dmem_we_i(dmem_we), .dmem_wstrb_i(dmem_wstrb), .dmem_addr_i(dmem_addr),
    .dmem_wdata_i(dmem_wdata), .dmem_rdata_o(dmem_rdata), .dmem_rvalid_o(dmem_rvalid),
    .dmem_err_o(dmem_err), .dmem_busy_o(dmem_busy),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_wstrb_o(bus_wstrb), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet();
    imem_req = 0; imem_kill = 0; dmem_req = 0; dmem_we = 0; dmem_wstrb = 0;
    bus_gnt = 0; bus_rvalid = 0;
  endtask
  task automatic test_reset();
    rst = 1; imem_req = 1; imem_addr = 32'h80; dmem_req = 1; bus_rdata = 32'hA5A5_0001;
    nxt(); #2;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
    checks++; if (imem_busy !== 1'b0 || dmem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b exp 00", imem_busy, dmem_busy); end
    checks++; if (imem_rdata !== 32'hA5A5_0001 || dmem_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_rdata got %h/%h exp a5a50001", imem_rdata, dmem_rdata); end
    nxt(); quiet(); rst = 0;
  endtask
  task automatic test_lone_fetch();
    nxt(); imem_req = 1; imem_addr = 32'h100; bus_gnt = 1; #2;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0) begin errors++; $display("FAIL lone_c0_bus got req=%b addr=%h we=%b exp 1/100/0", bus_req, bus_addr, bus_we); end
    checks++; if (imem_busy !== 1'b1) begin errors++; $display("FAIL lone_c0_busy got %b exp 1", imem_busy); end
    nxt(); bus_gnt = 0; #2;
    checks++; if (bus_req !== 1'b0 || bus_addr !== 32'h0 || imem_busy !== 1'b1 || imem_rvalid !== 1'b0) begin errors++; $display("FAIL lone_c1 got req=%b addr=%h busy=%b rv=%b exp 0/0/1/0", bus_req, bus_addr, imem_busy, imem_rvalid); end
    nxt(); bus_rvalid = 1; bus_rdata = 32'h13; #2;
    checks++; if (imem_rvalid !== 1'b1 || imem_rdata !== 32'h13 || imem_busy !== 1'b0) begin errors++; $display("FAIL lone_c2 got rv=%b data=%h busy=%b exp 1/13/0", imem_rvalid, imem_rdata, imem_busy); end
    nxt(); quiet(); #2;
    checks++; if (imem_rvalid !== 1'b0) begin errors++; $display("FAIL lone_pulse got %b exp 0", imem_rvalid); end
  endtask
  task automatic test_contention();
    nxt(); imem_req = 1; imem_addr = 32'h100; dmem_req = 1; dmem_we = 1; dmem_addr = 32'h2000;
    dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF; bus_gnt = 1; #2;
    checks++; if (bus_we !== 1'b1 || bus_addr !== 32'h2000 || bus_wdata !== 32'hDEADBEEF || bus_wstrb !== 4'hF) begin errors++; $display("FAIL cont_store got we=%b addr=%h wd=%h st=%h exp 1/2000/deadbeef/f", bus_we, bus_addr, bus_wdata, bus_wstrb); end
    checks++; if (imem_busy !== 1'b1 || dmem_busy !== 1'b1) begin errors++; $display("FAIL cont_busy got %b%b exp 11", imem_busy, dmem_busy); end
    nxt(); bus_gnt = 0; bus_rvalid = 1; #2;
    checks++; if (dmem_rvalid !== 1'b1 || imem_rvalid !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL cont_ack got drv=%b irv=%b req=%b exp 1/0/0", dmem_rvalid, imem_rvalid, bus_req); end
    nxt(); dmem_req = 0; dmem_we = 0; bus_rvalid = 0; bus_gnt = 1; #2;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0 || bus_wstrb !== 4'h0 || bus_wdata !== 32'h0) begin errors++; $display("FAIL cont_fetch got req=%b addr=%h we=%b st=%h wd=%h exp 1/100/0/0/0", bus_req, bus_addr, bus_we, bus_wstrb, bus_wdata); end
    nxt(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h1234; #2;
    checks++; if (imem_rvalid !== 1'b1 || imem_rdata !== 32'h1234) begin errors++; $display("FAIL cont_fetch_rv got %b/%h exp 1/1234", imem_rvalid, imem_rdata); end
    nxt(); quiet();
  endtask
  task automatic test_starvation();
    logic [31:0] exp_addr;
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h3000; imem_req = 1; imem_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      exp_addr = (k == 4) ? 32'h200 : 32'h3000;
      bus_gnt = 1; bus_rvalid = 0; #2;
      checks++; if (bus_req !== 1'b1 || bus_addr !== exp_addr) begin errors++; $display("FAIL starve_txn%0d got req=%b addr=%h exp 1/%h", k, bus_req, bus_addr, exp_addr); end
      nxt(); bus_gnt = 0; bus_rvalid = 1; #2;
      checks++; if (imem_rvalid !== (k == 4) || dmem_rvalid !== (k != 4)) begin errors++; $display("FAIL starve_rv%0d got i=%b d=%b exp %b/%b", k, imem_rvalid, dmem_rvalid, k == 4, k != 4); end
      nxt();
    end
    quiet();
  endtask
  task automatic test_kill_resp();
    nxt(); imem_req = 1; imem_addr = 32'h300; bus_gnt = 1; #2;
    checks++; if (bus_addr !== 32'h300) begin errors++; $display("FAIL kill_issue got %h exp 300", bus_addr); end
    nxt(); bus_gnt = 0; imem_kill = 1; #2;
    checks++; if (imem_busy !== 1'b0 || imem_rvalid !== 1'b0) begin errors++; $display("FAIL kill_c1 got busy=%b rv=%b exp 0/0", imem_busy, imem_rvalid); end
    nxt(); imem_kill = 0; imem_addr = 32'h400; bus_rvalid = 1; bus_rdata = 32'h99; #2;
    checks++; if (imem_rvalid !== 1'b0 || imem_busy !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL kill_drop got rv=%b busy=%b req=%b exp 0/1/0", imem_rvalid, imem_busy, bus_req); end
    nxt(); bus_rvalid = 0; bus_gnt = 1; #2;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin errors++; $display("FAIL kill_refetch got req=%b addr=%h exp 1/400", bus_req, bus_addr); end
    nxt(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h77; #2;
    checks++; if (imem_rvalid !== 1'b1 || imem_rdata !== 32'h77) begin errors++; $display("FAIL kill_refetch_rv got %b/%h exp 1/77", imem_rvalid, imem_rdata); end
    nxt(); quiet();
  endtask
  task automatic test_timeout();
    nxt(); dmem_req = 1; dmem_we = 0; dmem_addr = 32'h500;
    for (int c = 0; c < 8; c++) begin
      #2;
      checks++; if (dmem_err !== 1'b0 || bus_req !== 1'b1 || dmem_busy !== 1'b1) begin errors++; $display("FAIL tmo_wait%0d got err=%b req=%b busy=%b exp 0/1/1", c, dmem_err, bus_req, dmem_busy); end
      nxt();
    end
    #2;
    checks++; if (dmem_err !== 1'b1 || dmem_busy !== 1'b0 || imem_err !== 1'b0) begin errors++; $display("FAIL tmo_fire got err=%b busy=%b ierr=%b exp 1/0/0", dmem_err, dmem_busy, imem_err); end
    nxt(); dmem_req = 0; bus_rvalid = 1; #2;
    checks++; if (dmem_rvalid !== 1'b0 || imem_rvalid !== 1'b0 || dmem_err !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL tmo_stray got drv=%b irv=%b err=%b req=%b exp 0/0/0/0", dmem_rvalid, imem_rvalid, dmem_err, bus_req); end
    nxt(); quiet();
  endtask
  task automatic test_reset_mid();
    nxt(); imem_req = 1; imem_addr = 32'h600; bus_gnt = 1; #2;
    checks++; if (bus_addr !== 32'h600) begin errors++; $display("FAIL rstmid_issue got %h exp 600", bus_addr); end
    nxt(); bus_gnt = 0; rst = 1; bus_rvalid = 1; #2;
    checks++; if (bus_req !== 1'b0 || imem_rvalid !== 1'b0 || imem_busy !== 1'b0) begin errors++; $display("FAIL rstmid_in_reset got req=%b rv=%b busy=%b exp 0/0/0", bus_req, imem_rvalid, imem_busy); end
    nxt(); rst = 0; imem_req = 0; #2;
    checks++; if (imem_rvalid !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_late_rv got rv=%b req=%b exp 0/0", imem_rvalid, bus_req); end
    nxt(); bus_rvalid = 0; imem_req = 1; imem_addr = 32'h700; bus_gnt = 1; #2;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h700) begin errors++; $display("FAIL rstmid_fresh got req=%b addr=%h exp 1/700", bus_req, bus_addr); end
    nxt(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h55; #2;
    checks++; if (imem_rvalid !== 1'b1 || imem_rdata !== 32'h55) begin errors++; $display("FAIL rstmid_fresh_rv got %b/%h exp 1/55", imem_rvalid, imem_rdata); end
    nxt(); quiet();
  endtask
  initial begin
    test_reset();
    test_lone_fetch();
    test_contention();
    test_starvation();
    test_kill_resp();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
